// File: rtl/meter_pkg.sv
// Shared constants, request indexing and FSM encoding for the parking-meter
// credit sequencer.
package meter_pkg;

  localparam int COUNT_W          = 14;
  localparam int BCD_W            = 16;
  localparam int MAX_COUNT_DEF    = 9999;
  localparam int FLASH_THRESH_DEF = 200;

  // Service sources, numbered so that a higher index means higher priority.
  // Adds occupy 0..NUM_ADD-1 in add_req bit order (+10, +180, +200, +550).
  localparam int NUM_ADD    = 4;
  localparam int SRC_TICK   = 4;
  localparam int SRC_PRE10  = 5;
  localparam int SRC_PRE205 = 6;
  localparam int NUM_SRC    = 7;

  localparam logic [COUNT_W-1:0] ADD_AMT [NUM_ADD] = '{14'd10, 14'd180, 14'd200, 14'd550};
  localparam logic [COUNT_W-1:0] PRESET_VAL [2]    = '{14'd10, 14'd205};

  typedef enum logic {IDLE, CONV} state_t;

  // One-hot grant of the highest-index set request bit.
  function automatic logic [NUM_SRC-1:0] pick_highest(input logic [NUM_SRC-1:0] req);
    logic [NUM_SRC-1:0] grant;
    grant = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one shift per clock, done pulses for one
// cycle once all COUNT_W bits have been shifted in.
module bin2bcd_seq
  import meter_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] bin,
  output logic [BCD_W-1:0]   bcd,
  output logic               done
);

  localparam logic [3:0] STEPS = 4'(COUNT_W);

  logic [COUNT_W-1:0] shreg;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   adj;
  logic [3:0]         cnt;
  logic               active;

  always_comb begin
    adj = acc;
    for (int n = 0; n < BCD_W / 4; n++) begin
      if (acc[4*n +: 4] >= 4'd5) adj[4*n +: 4] = acc[4*n +: 4] + 4'd3;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg  <= '0;
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg  <= bin;
        acc    <= '0;
        cnt    <= STEPS;
        active <= 1'b1;
      end else if (active) begin
        acc   <= {adj[BCD_W-2:0], shreg[COUNT_W-1]};
        shreg <= shreg << 1;
        cnt   <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign bcd = acc;

endmodule

// File: rtl/meter_ctrl.sv
// Parking-meter credit sequencer: queues button/preset/tick requests, applies
// them one at a time to a saturating count, then refreshes the BCD image.
module meter_ctrl
  import meter_pkg::*;
#(
  parameter int MAX_COUNT    = MAX_COUNT_DEF,
  parameter int FLASH_THRESH = FLASH_THRESH_DEF,
  parameter int PEND_W       = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic [NUM_ADD-1:0] add_req,
  input  logic [1:0]         preset_req,
  output logic [COUNT_W-1:0] count,
  output logic [BCD_W-1:0]   bcd,
  output logic               bcd_valid,
  output logic               flash,
  output logic               expired,
  output logic               busy,
  output logic               drop
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t               state, state_nxt;
  logic [PEND_W-1:0]    pend     [NUM_ADD];
  logic [PEND_W-1:0]    pend_dec [NUM_ADD];
  logic [PEND_W-1:0]    pend_nxt [NUM_ADD];
  logic [NUM_ADD-1:0]   lost;
  logic                 tick_pend, pre10_pend, pre205_pend;
  logic [NUM_SRC-1:0]   pend_vec, grant, svc;
  logic                 start, conv_done;
  logic [BCD_W-1:0]     conv_bcd;
  logic [COUNT_W-1:0]   alu_result;
  logic [COUNT_W:0]     sum;

  always_comb begin
    for (int i = 0; i < NUM_ADD; i++) pend_vec[i] = (pend[i] != '0);
    pend_vec[SRC_TICK]   = tick_pend;
    pend_vec[SRC_PRE10]  = pre10_pend;
    pend_vec[SRC_PRE205] = pre205_pend;
  end

  assign grant = pick_highest(pend_vec);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pend_vec) state_nxt = CONV;
      CONV:    if (conv_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    svc   = '0;
    if (state == IDLE && |pend_vec) begin
      start = 1'b1;
      svc   = grant;
    end
  end

  assign busy = (state != IDLE);

  // Adds are evaluated one bit wider so the clamp sees the true sum.
  always_comb begin
    alu_result = count;
    sum        = '0;
    if (svc[SRC_PRE205])     alu_result = PRESET_VAL[1];
    else if (svc[SRC_PRE10]) alu_result = PRESET_VAL[0];
    else if (svc[SRC_TICK])  alu_result = (count == '0) ? '0 : count - 1'b1;
    else begin
      for (int i = 0; i < NUM_ADD; i++) begin
        if (svc[i]) begin
          sum        = {1'b0, count} + {1'b0, ADD_AMT[i]};
          alu_result = (sum > (COUNT_W+1)'(MAX_COUNT)) ? COUNT_W'(MAX_COUNT) : sum[COUNT_W-1:0];
        end
      end
    end
  end

  // Service decrements first, so a pulse arriving alongside its own service is kept.
  always_comb begin
    for (int i = 0; i < NUM_ADD; i++) begin
      pend_dec[i] = pend[i] - PEND_W'(svc[i]);
      lost[i]     = add_req[i] && (pend_dec[i] == PEND_MAX);
      pend_nxt[i] = (add_req[i] && !lost[i]) ? pend_dec[i] + 1'b1 : pend_dec[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ADD; i++) pend[i] <= '0;
      tick_pend   <= 1'b0;
      pre10_pend  <= 1'b0;
      pre205_pend <= 1'b0;
      drop        <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ADD; i++) pend[i] <= pend_nxt[i];
      tick_pend   <= (tick_pend   && !svc[SRC_TICK])   || tick;
      pre10_pend  <= (pre10_pend  && !svc[SRC_PRE10])  || preset_req[0];
      pre205_pend <= (pre205_pend && !svc[SRC_PRE205]) || preset_req[1];
      drop        <= |lost;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count     <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b1;
    end else begin
      if (start) begin
        count     <= alu_result;
        bcd_valid <= 1'b0;
      end
      if (state == CONV && conv_done) begin
        bcd       <= conv_bcd;
        bcd_valid <= 1'b1;
      end
    end
  end

  assign flash   = (count < COUNT_W'(FLASH_THRESH));
  assign expired = (count == '0);

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bin     (alu_result),
    .bcd     (conv_bcd),
    .done    (conv_done)
  );

endmodule

// File: tb/tb_meter_ctrl.sv
// Directed bench for meter_ctrl: expected counts are queued as requests are
// driven and checked, with their decimal BCD image, on each bcd_valid rise.
module tb_meter_ctrl;

  logic        clk;
  logic        reset_n;
  logic        tick;
  logic [3:0]  add_req;
  logic [1:0]  preset_req;
  logic [13:0] count;
  logic [15:0] bcd;
  logic        bcd_valid, flash, expired, busy, drop;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int drop_cnt = 0;
  logic valid_prev = 1'b1;

  meter_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .add_req    (add_req),
    .preset_req (preset_req),
    .count      (count),
    .bcd        (bcd),
    .bcd_valid  (bcd_valid),
    .flash      (flash),
    .expired    (expired),
    .busy       (busy),
    .drop       (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Scoreboard: each completed conversion retires the oldest expected count.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bcd_valid === 1'b1 && valid_prev === 1'b0) begin
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        int e;
        e = exp_q.pop_front();
        check("sb_count", count, e);
        check("sb_bcd", bcd, to_bcd(e));
      end
    end
    valid_prev = bcd_valid;
    if (reset_n === 1'b1 && drop === 1'b1) drop_cnt++;
  end

  task automatic pulse(input logic [3:0] a, input logic [1:0] p, input logic t);
    @(negedge clk);
    add_req = a; preset_req = p; tick = t;
    @(negedge clk);
    add_req = '0; preset_req = '0; tick = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int n = 0;
    while (quiet < 2 && n < 400) begin
      @(negedge clk);
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    check("idle_timeout", quiet >= 2, 1);
  endtask

  task automatic op(input logic [3:0] a, input logic [1:0] p, input logic t, input int e);
    exp_q.push_back(e);
    pulse(a, p, t);
    wait_idle();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_bcd"}, bcd, 0);
    check({tag, "_bcd_valid"}, bcd_valid, 1);
    check({tag, "_flash"}, flash, 1);
    check({tag, "_expired"}, expired, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_drop"}, drop, 0);
  endtask

  initial begin
    int d0;
    reset_n = 1'b0; tick = 1'b0; add_req = '0; preset_req = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_reset_state("reset");

    // Preset 205 with exact latency
    exp_q.push_back(205);
    pulse(4'b0000, 2'b10, 1'b0);
    check("pre_not_yet", count, 0);
    @(negedge clk);
    check("pre_count", count, 205);
    check("pre_busy", busy, 1);
    check("pre_valid_low", bcd_valid, 0);
    repeat (14) @(negedge clk);
    check("pre_valid_early", bcd_valid, 0);
    @(negedge clk);
    check("pre_valid_rise", bcd_valid, 1);
    check("pre_bcd", bcd, 16'h0205);
    check("pre_flash", flash, 0);
    check("pre_expired", expired, 0);
    wait_idle();

    // Tick countdown across the flash threshold
    for (int v = 204; v >= 200; v--) op(4'b0000, 2'b00, 1'b1, v);
    check("flash_at_200", flash, 0);
    exp_q.push_back(199);
    pulse(4'b0000, 2'b00, 1'b1);
    @(negedge clk);
    check("tick_199", count, 199);
    check("flash_at_199", flash, 1);
    wait_idle();

    // Down to zero, then underflow ticks
    op(4'b0000, 2'b01, 1'b0, 10);
    for (int v = 9; v >= 0; v--) op(4'b0000, 2'b00, 1'b1, v);
    op(4'b0000, 2'b00, 1'b1, 0);
    op(4'b0000, 2'b00, 1'b1, 0);
    check("underflow_count", count, 0);
    check("underflow_expired", expired, 1);

    // Build 100, then all adds plus a tick in one cycle
    op(4'b0000, 2'b01, 1'b0, 10);
    for (int k = 2; k <= 10; k++) op(4'b0001, 2'b00, 1'b0, 10 * k);
    exp_q.push_back(99);
    exp_q.push_back(649);
    exp_q.push_back(849);
    exp_q.push_back(1029);
    exp_q.push_back(1039);
    pulse(4'b1111, 2'b00, 1'b1);
    @(negedge clk);
    check("simul_first", count, 99);
    repeat (16) @(negedge clk);
    check("simul_spacing", count, 649);
    wait_idle();
    check("simul_final_bcd", bcd, 16'h1039);

    // Saturation
    op(4'b0000, 2'b01, 1'b0, 10);
    for (int k = 1; k <= 19; k++) begin
      exp_q.push_back((10 + 550 * k > 9999) ? 9999 : 10 + 550 * k);
      pulse(4'b1000, 2'b00, 1'b0);
      repeat (18) @(negedge clk);
    end
    wait_idle();
    check("sat_count", count, 9999);
    check("sat_bcd", bcd, 16'h9999);
    op(4'b0000, 2'b00, 1'b1, 9998);
    check("sat_tick", count, 9998);

    // Pending counter overflow: four +10 pulses during a conversion
    op(4'b0000, 2'b01, 1'b0, 10);
    d0 = drop_cnt;
    exp_q.push_back(20);
    pulse(4'b0001, 2'b00, 1'b0);
    @(negedge clk);
    check("ovf_busy", busy, 1);
    exp_q.push_back(30);
    exp_q.push_back(40);
    exp_q.push_back(50);
    add_req = 4'b0001;
    repeat (4) @(negedge clk);
    add_req = '0;
    wait_idle();
    check("ovf_drops", drop_cnt - d0, 1);
    check("ovf_count", count, 50);

    // Reset during a conversion with adds still pending
    op(4'b0000, 2'b01, 1'b0, 10);
    pulse(4'b1100, 2'b00, 1'b0);
    @(negedge clk);
    check("mid_service", count, 560);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    reset_n = 1'b1;
    check_reset_state("midrst");
    repeat (60) @(negedge clk);
    check("midrst_after_count", count, 0);
    check("midrst_after_busy", busy, 0);
    check("midrst_after_valid", bcd_valid, 1);

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
